// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces the raw coin sensor, classifies each
// coin as Rs5/Rs10 and emits a one-cycle coin code, a reject pulse when inhibited,
// and a sticky jam flag when the coin stays in the chute too long.
// Optional feature macro: COIN_ACCEPTOR_TALLY_EN adds the saturating credit_total port.
module coin_acceptor #(
    parameter int unsigned DEB_CYCLES   = 4,
    parameter int unsigned STUCK_CYCLES = 1024,
    parameter int unsigned TALLY_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_present,
    input  logic               coin_is10,
    input  logic               inhibit,
    output logic [1:0]         coin_code,
    output logic               reject,
    output logic               busy,
    output logic               jam
`ifdef COIN_ACCEPTOR_TALLY_EN
    ,
    output logic [TALLY_W-1:0] credit_total
`endif
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
    localparam int unsigned STK_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [STK_W-1:0] STK_LAST = STK_W'(STUCK_CYCLES - 1);

    if (DEB_CYCLES < 2 || STUCK_CYCLES < 1 || TALLY_W < 1) begin : g_bad_param
        $error("coin_acceptor: DEB_CYCLES must be >= 2, STUCK_CYCLES and TALLY_W >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_EMIT,
        S_RELEASE,
        S_JAM
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [STK_W-1:0] stuck, stuck_n;
    logic [1:0]       code_n;
    logic             reject_n;
    logic [1:0]       pres_sync;
    logic [1:0]       is10_sync;
    logic             s_present;
    logic             s_is10;

    assign s_present = pres_sync[1];
    assign s_is10    = is10_sync[1];

    // Two-flop synchronisers for the asynchronous sensor levels
    always_ff @(posedge clk) begin
        if (rst) begin
            pres_sync <= '0;
            is10_sync <= '0;
        end else begin
            pres_sync <= {pres_sync[0], coin_present};
            is10_sync <= {is10_sync[0], coin_is10};
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        stuck_n  = stuck;
        code_n   = 2'b00;
        reject_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (s_present) begin
                    state_n = S_DEBOUNCE;
                    cnt_n   = '0;
                end
            end
            S_DEBOUNCE: begin
                if (!s_present) begin
                    state_n = S_IDLE;
                end else if (cnt == DEB_LAST) begin
                    // inhibit and size are sampled only on this edge
                    state_n = S_EMIT;
                    if (inhibit) begin
                        reject_n = 1'b1;
                    end else begin
                        code_n = s_is10 ? 2'b10 : 2'b01;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_EMIT: begin
                state_n = S_RELEASE;
                cnt_n   = '0;
                stuck_n = '0;
            end
            S_RELEASE: begin
                if (s_present) begin
                    // a bounce restarts the absence count; stuck time accumulates
                    cnt_n = '0;
                    if (stuck == STK_LAST) begin
                        state_n = S_JAM;
                    end else begin
                        stuck_n = stuck + 1'b1;
                    end
                end else if (cnt == DEB_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_JAM: begin
                state_n = S_JAM;
            end
            default: begin
                state_n = S_RELEASE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RELEASE;
            cnt       <= '0;
            stuck     <= '0;
            coin_code <= 2'b00;
            reject    <= 1'b0;
            jam       <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            stuck     <= stuck_n;
            coin_code <= code_n;
            reject    <= reject_n;
            jam       <= (state_n == S_JAM);
            busy      <= (state_n != S_IDLE);
        end
    end

`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [TALLY_W:0] credit_sum;

    // coin code value equals its worth in Rs5 units
    assign credit_sum = {1'b0, credit_total} + (TALLY_W + 1)'(coin_code);

    // Saturating credit accumulator, updated on the EMIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_total <= '0;
        end else if (state == S_EMIT) begin
            credit_total <= credit_sum[TALLY_W] ? '1 : credit_sum[TALLY_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: scoreboard bench for coin_acceptor (DEB_CYCLES=4, STUCK_CYCLES=32, TALLY_W=4).
module tb_coin_acceptor;

    localparam int unsigned DEB   = 4;
    localparam int unsigned STUCK = 32;
    localparam int unsigned TW    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_present = 1'b0;
    logic       coin_is10 = 1'b0;
    logic       inhibit = 1'b0;
    logic [1:0] coin_code;
    logic       reject;
    logic       busy;
    logic       jam;
`ifdef COIN_ACCEPTOR_TALLY_EN
    logic [TW-1:0] credit_total;
`endif

    int          total = 0;
    int          bad = 0;
    int unsigned exp_credit = 0;
    logic [2:0]  sb_q[$];
    logic [2:0]  mon_exp;

    always #5 clk = ~clk;

    coin_acceptor #(
        .DEB_CYCLES  (DEB),
        .STUCK_CYCLES(STUCK),
        .TALLY_W     (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_present(coin_present),
        .coin_is10   (coin_is10),
        .inhibit     (inhibit),
        .coin_code   (coin_code),
        .reject      (reject),
        .busy        (busy),
        .jam         (jam)
`ifdef COIN_ACCEPTOR_TALLY_EN
        ,
        .credit_total(credit_total)
`endif
    );

    // Event monitor: every reject/code pulse must match the next scoreboard entry {reject, code}
    always @(negedge clk) begin
        if (!rst && (coin_code !== 2'b00 || reject !== 1'b0)) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event got reject=%0b code=%b want no event", reject, coin_code);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({reject, coin_code} !== mon_exp) begin
                    bad++;
                    $display("FAIL event got reject=%0b code=%b want reject=%0b code=%b",
                             reject, coin_code, mon_exp[2], mon_exp[1:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_event(input logic [2:0] ev);
        sb_q.push_back(ev);
        if (ev[2] == 1'b0) begin
            exp_credit = exp_credit + ev[1:0];
            if (exp_credit > 15) exp_credit = 15;
        end
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy got %b want 0 within %0d cycles", name, busy, max_cycles);
        end
    endtask

    task automatic check_sb_empty(input string name);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s pending events got %0d want 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_credit(input string name);
`ifdef COIN_ACCEPTOR_TALLY_EN
        total++;
        if (credit_total !== TW'(exp_credit)) begin
            bad++;
            $display("FAIL %s credit got %0d want %0d", name, credit_total, exp_credit);
        end
`else
        if (name.len() == 0) $display("empty check name");
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        coin_present = 1'b0;
        tick();
        tick();
        exp_credit = 0;
        total++; if (coin_code !== 2'b00) begin bad++; $display("FAIL reset_code got %b want 00", coin_code); end
        total++; if (reject !== 1'b0) begin bad++; $display("FAIL reset_reject got %b want 0", reject); end
        total++; if (jam !== 1'b0) begin bad++; $display("FAIL reset_jam got %b want 0", jam); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got %b want 1", busy); end
        check_credit("reset_credit");
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 3) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_release_busy got %b want 1", busy); end
            end
            if (k == 4) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_to_idle busy got %b want 0", busy); end
            end
        end
    endtask

    task automatic test_rs5();
        coin_is10 = 1'b0;
        inhibit = 1'b0;
        coin_present = 1'b1;
        expect_event(3'b001);
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 6 || k == 8) begin
                total++; if (coin_code !== 2'b00) begin bad++; $display("FAIL rs5_edge%0d code got %b want 00", k, coin_code); end
            end
            if (k == 7) begin
                total++; if (coin_code !== 2'b01) begin bad++; $display("FAIL rs5_edge7 code got %b want 01", coin_code); end
            end
            if (k == 17) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL rs5_release busy got %b want 1", busy); end
            end
            if (k == 18) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL rs5_idle busy got %b want 0", busy); end
            end
            if (k == 12) coin_present = 1'b0;
        end
        check_sb_empty("rs5");
        check_credit("rs5_credit");
    endtask

    task automatic test_glitch();
        coin_present = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) coin_present = 1'b0;
            if (k == 5) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_debounce busy got %b want 1", busy); end
            end
            if (k == 6) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle busy got %b want 0", busy); end
            end
        end
        check_sb_empty("glitch");
    endtask

    task automatic test_reject();
        // Rs10 while inhibited at the emit edge
        coin_is10 = 1'b1;
        inhibit = 1'b1;
        coin_present = 1'b1;
        expect_event(3'b100);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) begin
                total++; if (reject !== 1'b1) begin bad++; $display("FAIL reject_pulse got %b want 1", reject); end
                total++; if (coin_code !== 2'b00) begin bad++; $display("FAIL reject_code got %b want 00", coin_code); end
                inhibit = 1'b0;
            end
            if (k == 8) begin
                total++; if (reject !== 1'b0) begin bad++; $display("FAIL reject_width got %b want 0", reject); end
            end
        end
        coin_present = 1'b0;
        wait_idle(20, "reject_idle");
        check_sb_empty("reject");
        // inhibit high during debounce but low at the emit edge; size changes after it
        coin_is10 = 1'b0;
        inhibit = 1'b1;
        coin_present = 1'b1;
        expect_event(3'b001);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 5) inhibit = 1'b0;
            if (k == 7) begin
                inhibit = 1'b1;
                coin_is10 = 1'b1;
            end
        end
        coin_present = 1'b0;
        inhibit = 1'b0;
        wait_idle(20, "inhibit_window_idle");
        check_sb_empty("inhibit_window");
        check_credit("reject_credit");
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        pat = 8'b1100_1100;
        coin_is10 = 1'b1;
        coin_present = 1'b1;
        expect_event(3'b010);
        for (int k = 1; k <= 10; k++) tick();
        coin_is10 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            coin_present = pat[k];
            tick();
        end
        coin_present = 1'b0;
        wait_idle(30, "bounce_idle");
        check_sb_empty("bounce");
        check_credit("bounce_credit");
    endtask

    task automatic send_coin(input logic is10, input logic inh, input string name);
        coin_is10 = is10;
        inhibit = inh;
        coin_present = 1'b1;
        expect_event(inh ? 3'b100 : (is10 ? 3'b010 : 3'b001));
        for (int k = 1; k <= 8; k++) tick();
        coin_present = 1'b0;
        inhibit = 1'b0;
        wait_idle(20, name);
    endtask

    task automatic test_tally();
        send_coin(1'b1, 1'b1, "tally_rejected");
        check_credit("tally_rejected_credit");
        for (int i = 0; i < 12; i++) begin
            send_coin(i < 5, 1'b0, "tally_coin");
            check_credit("tally_credit");
        end
        check_sb_empty("tally");
    endtask

    task automatic test_reset_mid();
        coin_is10 = 1'b1;
        coin_present = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_credit = 0;
        total++; if (coin_code !== 2'b00) begin bad++; $display("FAIL reset_mid_code got %b want 00", coin_code); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_mid_busy got %b want 1", busy); end
        check_credit("reset_mid_credit");
        for (int k = 1; k <= 4; k++) tick();
        coin_present = 1'b0;
        wait_idle(20, "reset_mid_idle");
        check_sb_empty("reset_mid");
        check_credit("reset_mid_credit_after");
    endtask

    task automatic test_jam();
        coin_is10 = 1'b0;
        coin_present = 1'b1;
        expect_event(3'b001);
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 39) begin
                total++; if (jam !== 1'b0) begin bad++; $display("FAIL jam_early got %b want 0", jam); end
            end
            if (k == 40) begin
                total++; if (jam !== 1'b1) begin bad++; $display("FAIL jam_set got %b want 1", jam); end
            end
        end
        coin_present = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        total++; if (jam !== 1'b1) begin bad++; $display("FAIL jam_sticky got %b want 1", jam); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL jam_busy got %b want 1", busy); end
        coin_present = 1'b1;
        for (int k = 1; k <= 12; k++) tick();
        coin_present = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        total++; if (jam !== 1'b1) begin bad++; $display("FAIL jam_after_coin got %b want 1", jam); end
        check_sb_empty("jam");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_credit = 0;
        total++; if (jam !== 1'b0) begin bad++; $display("FAIL jam_clear got %b want 0", jam); end
        wait_idle(20, "jam_recover_idle");
    endtask

    initial begin
        test_reset();
        test_rs5();
        test_glitch();
        test_reject();
        test_bounce();
        test_tally();
        test_reset_mid();
        test_jam();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
